// File: rtl/change_dispenser.sv
// change_dispenser: returns change one coin at a time, largest denomination
// first (5, 2, 1). Each coin is handshaked with the return mechanism. Empty
// tubes are skipped. Completion is reported with done and failure with fault.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 1000,
  parameter int GAP_CYCLES  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic [2:0] tube_empty,
  input  logic       eject_ack,
  output logic       eject_req,
  output logic [1:0] eject_denom,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [3:0] coins_out
);

  // One shared timer covers both the ack wait and the settle gap.
  localparam int MAX_COUNT = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW        = $clog2(MAX_COUNT + 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  // Coin codes as they appear on eject_denom.
  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_1    = 2'd1;
  localparam logic [1:0] CODE_2    = 2'd2;
  localparam logic [1:0] CODE_5    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    GAP,
    FAULT
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   timer_reg;
  logic            eject_req_reg;
  logic [1:0]      eject_denom_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            fault_reg;
  logic [7:0]      remaining_reg;
  logic [3:0]      coins_out_reg;

  logic [1:0]      pick_code;
  logic [7:0]      coin_value;

  // Choose the largest coin that fits the owed amount and whose tube is stocked.
  always_comb begin
    pick_code = CODE_NONE;
    if (remaining_reg >= 8'd5 && !tube_empty[2]) begin
      pick_code = CODE_5;
    end else if (remaining_reg >= 8'd2 && !tube_empty[1]) begin
      pick_code = CODE_2;
    end else if (remaining_reg >= 8'd1 && !tube_empty[0]) begin
      pick_code = CODE_1;
    end
  end

  // Credit value of the coin currently being ejected.
  always_comb begin
    coin_value = 8'd0;
    case (eject_denom_reg)
      CODE_5:  coin_value = 8'd5;
      CODE_2:  coin_value = 8'd2;
      CODE_1:  coin_value = 8'd1;
      default: coin_value = 8'd0;
    endcase
  end

  // Dispense sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      eject_req_reg   <= 1'b0;
      eject_denom_reg <= CODE_NONE;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      fault_reg       <= 1'b0;
      remaining_reg   <= 8'd0;
      coins_out_reg   <= 4'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, FAULT: begin
          if (start) begin
            remaining_reg <= amount;
            coins_out_reg <= 4'd0;
            fault_reg     <= 1'b0;
            busy_reg      <= 1'b1;
            timer_reg     <= '0;
            state_reg     <= SELECT;
          end
        end

        SELECT: begin
          if (remaining_reg == 8'd0) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (pick_code != CODE_NONE) begin
            eject_req_reg   <= 1'b1;
            eject_denom_reg <= pick_code;
            timer_reg       <= '0;
            state_reg       <= EJECT;
          end else begin
            // No stocked tube can cover what is owed; remaining keeps the shortfall.
            fault_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= FAULT;
          end
        end

        EJECT: begin
          if (eject_ack) begin
            // An ack in the final timeout cycle still counts as delivered.
            eject_req_reg   <= 1'b0;
            eject_denom_reg <= CODE_NONE;
            remaining_reg   <= remaining_reg - coin_value;
            if (coins_out_reg != 4'd15) begin
              coins_out_reg <= coins_out_reg + 4'd1;
            end
            timer_reg <= '0;
            state_reg <= GAP;
          end else if (timer_reg == ACK_LAST) begin
            eject_req_reg   <= 1'b0;
            eject_denom_reg <= CODE_NONE;
            fault_reg       <= 1'b1;
            busy_reg        <= 1'b0;
            timer_reg       <= '0;
            state_reg       <= FAULT;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        GAP: begin
          if (timer_reg == GAP_LAST) begin
            timer_reg <= '0;
            state_reg <= SELECT;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign eject_req   = eject_req_reg;
  assign eject_denom = eject_denom_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign fault       = fault_reg;
  assign remaining   = remaining_reg;
  assign coins_out   = coins_out_reg;

endmodule
